// File: rtl/bcd_ctrl_pkg.sv
// Shared types and helpers for the BCD counter sequencing controller.
// Holds the controller state encoding, the digit limits and the preload clamp.
package bcd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] DIGIT_MIN = 4'd0;

  // Any preload nibble above 9 is forced to 9 so q never shows invalid BCD.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > DIGIT_MAX) ? DIGIT_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter: clear, clamped load, and up/down step with
// carry/borrow out, chained digit to digit by the top level.
module bcd_digit
  import bcd_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       up_down,
  input  logic       load,
  input  logic [3:0] load_d,
  input  logic       clr,
  output logic [3:0] d,
  output logic       carry_out
);

  // Carry (up) or borrow (down) into the next digit when this one rolls over.
  assign carry_out = en && (up_down ? (d == DIGIT_MAX) : (d == DIGIT_MIN));

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      d <= DIGIT_MIN;
    end else if (clr) begin
      d <= DIGIT_MIN;
    end else if (load) begin
      d <= bcd_clamp(load_d);
    end else if (en) begin
      if (up_down) begin
        d <= (d == DIGIT_MAX) ? DIGIT_MIN : d + 4'd1;
      end else begin
        d <= (d == DIGIT_MIN) ? DIGIT_MAX : d - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run/pause/clear/load sequencer for an N-digit BCD counter, stepping on a
// single-clock prescaler tick, with wrap-or-stop at the terminal count.
module bcd_count_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 50_000_000,
  parameter int DIV_W    = 27
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                up_down,
  input  logic                wrap_en,
  output logic [4*DIGITS-1:0] q,
  output logic                tick,
  output logic                tc,
  output logic                running,
  output logic                done
);

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);

  state_t             state;
  logic [DIV_W-1:0]   presc;
  logic [DIGITS-1:0]  dig_en;
  logic [DIGITS-1:0]  dig_carry;
  logic [DIGITS-1:0]  at_term;
  logic               terminal;
  logic               step;
  logic               ctl_override;

  assign ctl_override = clear || load;
  assign tick         = (state == RUN) && (presc == PRESC_LAST);

  // Terminal count depends on the direction presented in the tick cycle.
  assign terminal = &at_term;

  // A tick steps the digits unless clear/load overrides it or the count must
  // stop at terminal; wrapping is just the digits rolling over naturally.
  assign step = tick && !ctl_override && (wrap_en || !terminal);
  assign tc   = tick && !ctl_override && terminal && wrap_en;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_lsd
        assign dig_en[gi] = step;
      end else begin : g_chain
        assign dig_en[gi] = dig_carry[gi-1];
      end

      assign at_term[gi] = up_down ? (q[4*gi +: 4] == DIGIT_MAX)
                                   : (q[4*gi +: 4] == DIGIT_MIN);

      bcd_digit u_digit (
        .clk       (clk),
        .reset     (reset),
        .en        (dig_en[gi]),
        .up_down   (up_down),
        .load      (load),
        .load_d    (load_val[4*gi +: 4]),
        .clr       (clear),
        .d         (q[4*gi +: 4]),
        .carry_out (dig_carry[gi])
      );
    end
  endgenerate

  // Controller FSM and prescaler; running/done are registered with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      presc   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else if (ctl_override) begin
      state   <= IDLE;
      presc   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state   <= RUN;
            presc   <= '0;
            running <= 1'b1;
          end
        end
        RUN: begin
          presc <= tick ? '0 : presc + 1'b1;
          if (stop) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (tick && terminal && !wrap_en) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end
        end
        PAUSE: begin
          // Prescaler holds its value so a resume finishes the interrupted tick.
          if (start && !stop) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          presc   <= '0;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Self-checking bench for bcd_count_ctrl: an integer-valued reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_bcd_count_ctrl;

  localparam int D        = 2;
  localparam int W        = 4 * D;
  localparam int TICK_DIV = 4;
  localparam int DIV_W    = 3;
  localparam int MODULUS  = 100;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         clear = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         up_down = 1'b1;
  logic         wrap_en = 1'b1;
  logic [W-1:0] q;
  logic         tick;
  logic         tc;
  logic         running;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;
  int tc_count = 0;
  int tc_base;

  bcd_count_ctrl #(
    .DIGITS   (D),
    .TICK_DIV (TICK_DIV),
    .DIV_W    (DIV_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .up_down  (up_down),
    .wrap_en  (wrap_en),
    .q        (q),
    .tick     (tick),
    .tc       (tc),
    .running  (running),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] b;
    int t;
    b = '0;
    t = v;
    for (int i = 0; i < D; i++) begin
      b[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  function automatic int clamp_value(input logic [W-1:0] lv);
    int v;
    int w;
    int nib;
    v = 0;
    w = 1;
    for (int i = 0; i < D; i++) begin
      nib = int'(lv[4*i +: 4]);
      if (nib > 9) nib = 9;
      v = v + nib * w;
      w = w * 10;
    end
    return v;
  endfunction

  // Reference model: count held as a plain integer, state as a small code.
  int m_q = 0;
  int m_pre = 0;
  int m_st = M_IDLE;
  bit m_valid = 1'b0;

  always @(negedge clk) begin
    bit e_tick;
    bit e_term;
    bit e_tc;
    e_tick = (m_st == M_RUN) && (m_pre == TICK_DIV - 1);
    e_term = up_down ? (m_q == MODULUS - 1) : (m_q == 0);
    e_tc   = e_tick && e_term && wrap_en && !clear && !load;
    if (m_valid) begin
      check("q", 32'(q), 32'(to_bcd(m_q)));
      check("tick", 32'(tick), 32'(e_tick));
      check("tc", 32'(tc), 32'(e_tc));
      check("running", 32'(running), 32'(m_st == M_RUN));
      check("done", 32'(done), 32'(m_st == M_DONE));
    end
    if (tc === 1'b1) tc_count++;

    if (reset) begin
      m_q = 0; m_pre = 0; m_st = M_IDLE; m_valid = 1'b1;
    end else if (clear) begin
      m_q = 0; m_pre = 0; m_st = M_IDLE;
    end else if (load) begin
      m_q = clamp_value(load_val); m_pre = 0; m_st = M_IDLE;
    end else if (m_st == M_IDLE) begin
      if (start && !stop) begin m_st = M_RUN; m_pre = 0; end
    end else if (m_st == M_PAUSE) begin
      if (start && !stop) m_st = M_RUN;
    end else if (m_st == M_RUN) begin
      m_pre = e_tick ? 0 : m_pre + 1;
      if (e_tick && !(e_term && !wrap_en))
        m_q = up_down ? (m_q + 1) % MODULUS : (m_q + MODULUS - 1) % MODULUS;
      if (stop) m_st = M_PAUSE;
      else if (e_tick && e_term && !wrap_en) m_st = M_DONE;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset held, then start; first tick four cycles in.
    cyc(3);
    check("reset_q", 32'(q), 32'h00);
    check("reset_running", 32'(running), 32'h0);
    reset = 1'b0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("s1_running", 32'(running), 32'h1);
    cyc(3);
    check("s1_tick", 32'(tick), 32'h1);
    check("s1_q_before", 32'(q), 32'h00);
    cyc(1);
    check("s1_q_after", 32'(q), 32'h01);

    // 2: count up 100 ticks with wrap.
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    up_down = 1'b1;
    wrap_en = 1'b1;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    tc_base = tc_count;
    cyc(40);
    check("s2_q_10", 32'(q), 32'h10);
    cyc(360);
    check("s2_q_wrap", 32'(q), 32'h00);
    check("s2_tc_once", 32'(tc_count - tc_base), 32'd1);
    check("s2_running", 32'(running), 32'h1);

    // 3: count down from 03 without wrap into DONE.
    up_down = 1'b0;
    wrap_en = 1'b0;
    load_val = 8'h03;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    check("s3_loaded", 32'(q), 32'h03);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(12);
    check("s3_q_00", 32'(q), 32'h00);
    check("s3_not_done", 32'(done), 32'h0);
    cyc(4);
    check("s3_done", 32'(done), 32'h1);
    start = 1'b1;
    cyc(2);
    start = 1'b0;
    check("s3_start_ignored", 32'(done), 32'h1);
    check("s3_q_held", 32'(q), 32'h00);

    // 4: pause mid-prescale, resume finishes the remaining count only.
    up_down = 1'b1;
    load_val = 8'h20;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);
    stop = 1'b1;
    cyc(10);
    stop = 1'b0;
    check("s4_paused_q", 32'(q), 32'h20);
    check("s4_paused", 32'(running), 32'h0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("s4_resume_tick", 32'(tick), 32'h1);
    cyc(1);
    check("s4_q_after", 32'(q), 32'h21);

    // 5: clamped load, then clear during a terminal tick.
    load_val = 8'hA7;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    check("s5_clamp_a7", 32'(q), 32'h97);
    wrap_en = 1'b1;
    load_val = 8'h9F;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    check("s5_clamp_9f", 32'(q), 32'h99);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);
    clear = 1'b1;
    #1;
    check("s5_tick_with_clear", 32'(tick), 32'h1);
    check("s5_tc_suppressed", 32'(tc), 32'h0);
    cyc(1);
    clear = 1'b0;
    check("s5_cleared", 32'(q), 32'h00);
    check("s5_idle", 32'(running), 32'h0);

    // 6: start&&stop pauses; reset mid-run zeroes the count.
    load_val = 8'h44;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(4);
    check("s6_q_45", 32'(q), 32'h45);
    start = 1'b1;
    stop = 1'b1;
    cyc(1);
    start = 1'b0;
    stop = 1'b0;
    check("s6_stop_wins", 32'(running), 32'h0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("s6_resumed", 32'(running), 32'h1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("s6_reset_q", 32'(q), 32'h00);
    check("s6_reset_running", 32'(running), 32'h0);
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
